// File: rtl/matmul_row_engine.sv
// Row-at-a-time matrix multiply core: buffers one row of A, streams B columns through a
// signed MAC and emits C in row-major order.
`timescale 1ns/1ps

module matmul_row_engine #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ACC_WIDTH  = 64,
    parameter int C_MAX_K      = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    ap_start,
    output logic                    ap_idle,
    output logic                    ap_done,
    output logic                    size_err,
    input  logic [31:0]             nrows_A,
    input  logic [31:0]             ncols_A,
    input  logic [31:0]             ncols_B,
    input  logic                    a_tvalid,
    output logic                    a_tready,
    input  logic [C_DATA_WIDTH-1:0] a_tdata,
    input  logic                    b_tvalid,
    output logic                    b_tready,
    input  logic [C_DATA_WIDTH-1:0] b_tdata,
    output logic                    c_tvalid,
    input  logic                    c_tready,
    output logic [C_DATA_WIDTH-1:0] c_tdata,
    output logic                    c_tlast
);

    localparam int IDX_W = (C_MAX_K > 1) ? $clog2(C_MAX_K) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_A, MAC, EMIT, DONE} state_t;

    state_t state, state_next;

    logic [31:0]              m_dim, k_dim, n_dim;
    logic [31:0]              row_i, col_j, k_cnt;
    logic [C_ACC_WIDTH-1:0]   acc;
    logic                     early_done;
    logic                     size_err_q;
    logic [C_DATA_WIDTH-1:0]  row_buf [C_MAX_K];

    logic [IDX_W-1:0]               k_idx;
    logic signed [2*C_DATA_WIDTH-1:0] prod;
    logic signed [C_ACC_WIDTH-1:0]  prod_ext;
    logic                           last_k, col_last, row_last;
    logic                           start_zero, start_big, start_bad;

    assign k_idx    = k_cnt[IDX_W-1:0];
    assign prod     = $signed(row_buf[k_idx]) * $signed(b_tdata);
    assign prod_ext = C_ACC_WIDTH'(prod);
    assign last_k   = (k_cnt == k_dim - 32'd1);
    assign col_last = (col_j + 32'd1 == n_dim);
    assign row_last = (row_i + 32'd1 == m_dim);

    assign start_zero = (nrows_A == 32'd0) || (ncols_A == 32'd0) || (ncols_B == 32'd0);
    assign start_big  = !start_zero && (ncols_A > 32'(C_MAX_K));
    assign start_bad  = start_zero || start_big;

    assign size_err = size_err_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        a_tready   = 1'b0;
        b_tready   = 1'b0;
        c_tvalid   = 1'b0;
        c_tdata    = '0;
        c_tlast    = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_next = start_bad ? DONE : LOAD_A;
                end
            end
            LOAD_A: begin
                a_tready = 1'b1;
                if (a_tvalid && last_k) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                b_tready = 1'b1;
                if (b_tvalid && last_k) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                c_tvalid = 1'b1;
                c_tdata  = acc[C_DATA_WIDTH-1:0];
                c_tlast  = col_last;
                if (c_tready) begin
                    if (!col_last) begin
                        state_next = MAC;
                    end else if (!row_last) begin
                        state_next = LOAD_A;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Rejected jobs spend one extra cycle here so their done lands two cycles after start
                if (!early_done) begin
                    ap_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_dim      <= '0;
            k_dim      <= '0;
            n_dim      <= '0;
            row_i      <= '0;
            col_j      <= '0;
            k_cnt      <= '0;
            acc        <= '0;
            early_done <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        m_dim      <= nrows_A;
                        k_dim      <= ncols_A;
                        n_dim      <= ncols_B;
                        row_i      <= '0;
                        col_j      <= '0;
                        k_cnt      <= '0;
                        acc        <= '0;
                        early_done <= start_bad;
                        size_err_q <= start_big;
                    end
                end
                LOAD_A: begin
                    if (a_tvalid) begin
                        if (last_k) begin
                            k_cnt <= '0;
                            acc   <= '0;
                        end else begin
                            k_cnt <= k_cnt + 32'd1;
                        end
                    end
                end
                MAC: begin
                    if (b_tvalid) begin
                        acc   <= acc + prod_ext;
                        k_cnt <= last_k ? 32'd0 : k_cnt + 32'd1;
                    end
                end
                EMIT: begin
                    if (c_tready) begin
                        k_cnt <= '0;
                        acc   <= '0;
                        if (!col_last) begin
                            col_j <= col_j + 32'd1;
                        end else if (!row_last) begin
                            col_j <= '0;
                            row_i <= row_i + 32'd1;
                        end
                    end
                end
                DONE: begin
                    early_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Row buffer carries no reset; it is always rewritten before being read
    always_ff @(posedge aclk) begin
        if (state == LOAD_A && a_tvalid) begin
            row_buf[k_idx] <= a_tdata;
        end
    end

endmodule

// File: doc/matmul_row_engine.md
# matmul_row_engine

Compute core of the matrix-multiplier kernel. It sits between the A/B read-master streams and the C write-master stream. For each row i of A, it buffers A[i][0..K-1] locally, then consumes column j of B (K beats, replayed per row by the B reader) and multiply-accumulates. After each column it emits one C[i][j] beat, so results leave in row-major order. It runs once per ap_start pulse using dimensions latched at start.

## Interface
- C_DATA_WIDTH, 32: element width of A, B, C; signed two's complement.
- C_ACC_WIDTH, 64: accumulator width.
- C_MAX_K, 256: row-buffer depth; maximum supported ncols_A.
- aclk  in  1  sole clock; everything is on its rising edge.
- areset  in  1  synchronous, active-high reset.
- ap_start  in  1  single-cycle start pulse.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  one-cycle completion pulse.
- size_err  out  1  valid with ap_done; high means the job was rejected.
- nrows_A (M), ncols_A (K), ncols_B (N)  in  32 each  dimensions, sampled on ap_start.
- a_tvalid/a_tready  in/out  1  A stream handshake, row-major.
- a_tdata  in  C_DATA_WIDTH  A element.
- b_tvalid/b_tready  in/out  1  B stream handshake, column-major, full matrix repeated M times.
- b_tdata  in  C_DATA_WIDTH  B element.
- c_tvalid/c_tready  out/in  1  C stream handshake.
- c_tdata  out  C_DATA_WIDTH  C element.
- c_tlast  out  1  high on C[i][N-1].

## Operation
- States: IDLE, LOAD_A, MAC, EMIT, DONE.
- IDLE:
  - On ap_start, latch M, K, N and clear i, j, k.
  - If M, K or N is 0, go to DONE with size_err=0.
  - If K > C_MAX_K, go to DONE with size_err=1.
  - Otherwise go to LOAD_A.
  - ap_start is ignored in every other state.
- LOAD_A:
  - a_tready=1.
  - Each accepted beat writes row_buf[k] and increments k.
  - On the K-th beat: k←0, acc←0, go to MAC.
- MAC:
  - b_tready=1.
  - Each accepted beat does acc ← acc + sext(row_buf[k]) × sext(b_tdata), using a full 2·C_DATA_WIDTH signed product, then increments k.
  - The accumulator wraps modulo 2^C_ACC_WIDTH.
  - On the K-th beat, go to EMIT.
- EMIT:
  - c_tvalid=1, c_tdata=acc[C_DATA_WIDTH-1:0] (truncating wrap), c_tlast=(j==N-1).
  - On c_tready, j increments. Then:
    - j<N: acc←0, k←0, go to MAC.
    - j==N and i+1<M: j←0, i increments, go to LOAD_A.
    - j==N and i+1==M: go to DONE.
- DONE: ap_done=1 for exactly one cycle, then go to IDLE. size_err is held until the next accepted ap_start.
- a_tready, b_tready and c_tvalid are never high in any state other than the one named above.
- No surplus A/B beats are consumed. Beats beyond M·K (A) or M·N·K (B) stay on the bus.

## Timing
- Reset values: ap_idle=1, ap_done=0, size_err=0, a_tready=0, b_tready=0, c_tvalid=0, c_tdata=0, c_tlast=0. State returns to IDLE.
- Reset mid-job aborts immediately; no ap_done is produced.
- ap_start sampled at edge t → ap_idle=0 and ready asserted from t+1.
- Degenerate or error jobs: ap_done at t+2.
- Throughput is one A or B beat per cycle with no bubbles inside a run.
- In MAC, a beat accepted at edge e is reflected in acc at e+1.
- EMIT is entered the cycle after the K-th B beat, so c_tvalid rises one cycle after the last B handshake.
- C output is AXI-stream compliant: c_tdata and c_tlast are stable while c_tvalid=1 and c_tready=0.
- ap_done rises the cycle after the final C handshake.
- Per-row minimum latency is K + N·(K+1) cycles.

## Test plan
- Identity check: M=K=N=2, A=[[1,2],[3,4]], B=I (column-major 1,0,0,1, sent twice) → C=1,2,3,4. c_tlast on beats 2 and 4. ap_done one cycle after the last C handshake.
- Dot product: M=1, K=3, N=1, A=[1,2,3], B=[4,5,6] → C=32 with c_tlast=1. b_tready is never high before all 3 A beats are accepted.
- Signed wrap: K=2, A=[0x7FFFFFFF, 0x7FFFFFFF], B=[2, 2] → acc=0x1_FFFFFFFC, c_tdata=0xFFFFFFFC. With A=[-3], B=[5] → 0xFFFFFFF1.
- Backpressure: 2x2x2 with c_tready low for 5 cycles on each C beat → c_tdata stable while stalled, b_tready=0 throughout EMIT, results identical to the unstalled run.
- Degenerate and error cases:
  - N=0 → ap_done at start+2, size_err=0, no handshakes.
  - K=C_MAX_K+1 → ap_done at start+2, size_err=1.
  - A second ap_start while busy is ignored.
- Reset mid-MAC: areset high for 1 cycle during row 0 → all outputs at reset values next cycle, no ap_done. A fresh 1x1x1 job (A=7, B=6) then returns C=42.
